// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard transmitter:
//   - ps2_state_e : transmitter FSM states
//   - scan_code_t : 8-bit set-2 scan code
//   - BREAK_CODE  : set-2 break prefix (F0)
//   - FRAME_BITS  : start + 8 data + parity + stop
//   - odd_parity / build_frame helpers
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BIT  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_state_e;

    typedef logic [7:0] scan_code_t;

    localparam scan_code_t BREAK_CODE = 8'hF0;

    localparam int FRAME_BITS = 11;
    localparam int BIT_CNT_W  = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    // Parity bit that makes data plus parity carry an odd number of ones.
    function automatic logic odd_parity(input scan_code_t d);
        return ~(^d);
    endfunction

    // Frame laid out LSB first in transmit order: start, d0..d7, parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input scan_code_t d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ascii2scan.sv
// -----------------------------------------------------------------------------
// ascii2scan
// Combinational ASCII -> PS/2 set-2 make-code lookup.
// Digits '0'-'9' and letters (either case) are mapped; everything else
// reports hit=0 with code=0.
// Ports:
//   ascii : input  [7:0]  character
//   hit   : output        character is mapped
//   code  : output [7:0]  set-2 make code (valid when hit)
// -----------------------------------------------------------------------------
module ascii2scan
    import ps2_pkg::*;
(
    input  logic [7:0] ascii,
    output logic       hit,
    output scan_code_t code
);

    logic [7:0] up;

    always_comb begin
        // Fold lower case onto upper case so one table serves both.
        up = ascii;
        if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            up = ascii - 8'h20;
        end

        hit  = 1'b1;
        code = 8'h00;
        case (up)
            8'h30: code = 8'h45;  // 0
            8'h31: code = 8'h16;
            8'h32: code = 8'h1E;
            8'h33: code = 8'h26;
            8'h34: code = 8'h25;
            8'h35: code = 8'h2E;
            8'h36: code = 8'h36;
            8'h37: code = 8'h3D;
            8'h38: code = 8'h3E;
            8'h39: code = 8'h46;  // 9
            8'h41: code = 8'h1C;  // A
            8'h42: code = 8'h32;
            8'h43: code = 8'h21;
            8'h44: code = 8'h23;
            8'h45: code = 8'h24;
            8'h46: code = 8'h2B;
            8'h47: code = 8'h34;
            8'h48: code = 8'h33;
            8'h49: code = 8'h43;
            8'h4A: code = 8'h3B;
            8'h4B: code = 8'h42;
            8'h4C: code = 8'h4B;
            8'h4D: code = 8'h3A;
            8'h4E: code = 8'h31;
            8'h4F: code = 8'h44;
            8'h50: code = 8'h4D;
            8'h51: code = 8'h15;
            8'h52: code = 8'h2D;
            8'h53: code = 8'h1B;
            8'h54: code = 8'h2C;
            8'h55: code = 8'h3C;
            8'h56: code = 8'h2A;
            8'h57: code = 8'h1D;
            8'h58: code = 8'h22;
            8'h59: code = 8'h35;
            8'h5A: code = 8'h1A;  // Z
            default: begin
                hit  = 1'b0;
                code = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_tx
// Turns an accepted ASCII character into PS/2 keyboard traffic: the set-2
// make code, then F0, then the make code again, each byte followed by GAP
// idle cycles. Frames are 11 bits (start, 8 data LSB first, odd parity,
// stop); each bit lasts 2*CLK_DIV cycles with data changing while ps2_clk
// is high. Unsupported characters pulse err and send nothing.
//
// Build option: PS2_TX_BREAK_EN
//   defined   -> make, F0, make
//   undefined -> make only (one frame, one gap)
//
// Parameters:
//   CLK_DIV : clk cycles per PS/2 clock half-period (>= 2)
//   GAP     : idle clk cycles after each byte
// Ports:
//   clk      : input   system clock
//   rst      : input   asynchronous active-high reset
//   ascii    : input   [7:0] character to send
//   in_valid : input   ascii valid
//   in_ready : output  ready to accept (IDLE only)
//   ps2_clk  : output  generated PS/2 clock, idle high
//   ps2_data : output  PS/2 data, idle high
//   busy     : output  sequence in progress
//   err      : output  one-cycle pulse for an unsupported character
// -----------------------------------------------------------------------------
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int GAP     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ascii,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       err
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    // Index of the final byte of the sequence (0 = make, 1 = F0, 2 = make).
`ifdef PS2_TX_BREAK_EN
    localparam logic [1:0] SEQ_LAST = 2'd2;
`else
    localparam logic [1:0] SEQ_LAST = 2'd0;
`endif

    ps2_state_e            state_q,     state_d;
    logic                  hit_q,       hit_d;
    scan_code_t            code_q,      code_d;
    logic [1:0]            seq_q,       seq_d;
    logic [FRAME_BITS-1:0] shift_q,     shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [DIV_W-1:0]      div_cnt_q,   div_cnt_d;
    logic                  phase_low_q, phase_low_d;
    logic [GAP_W-1:0]      gap_cnt_q,   gap_cnt_d;
    logic                  ps2_clk_q,   ps2_clk_d;
    logic                  ps2_data_q,  ps2_data_d;
    logic                  err_q,       err_d;

    logic                  scan_hit;
    scan_code_t            scan_code;
    scan_code_t            cur_byte;
    logic [FRAME_BITS-1:0] frame;

    // Lookup on the live input; the result is captured at accept so later
    // changes of ascii have no effect.
    ascii2scan u_ascii2scan (
        .ascii (ascii),
        .hit   (scan_hit),
        .code  (scan_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hit_q       <= 1'b0;
            code_q      <= '0;
            seq_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            phase_low_q <= 1'b0;
            gap_cnt_q   <= '0;
            ps2_clk_q   <= 1'b1;
            ps2_data_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            code_q      <= code_d;
            seq_q       <= seq_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            phase_low_q <= phase_low_d;
            gap_cnt_q   <= gap_cnt_d;
            ps2_clk_q   <= ps2_clk_d;
            ps2_data_q  <= ps2_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        code_d      = code_q;
        seq_d       = seq_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        phase_low_d = phase_low_q;
        gap_cnt_d   = gap_cnt_q;
        ps2_clk_d   = ps2_clk_q;
        ps2_data_d  = ps2_data_q;
        err_d       = 1'b0;

        // Middle byte of the sequence is the break prefix.
        cur_byte = (seq_q == 2'd1) ? BREAK_CODE : code_q;
        frame    = build_frame(cur_byte);

        case (state_q)
            ST_IDLE: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (in_valid) begin
                    hit_d   = scan_hit;
                    code_d  = scan_code;
                    seq_d   = 2'd0;
                    err_d   = ~scan_hit;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!hit_q) begin
                    state_d = ST_IDLE;
                end else begin
                    // Start bit goes out on the same edge that enters BIT.
                    shift_d     = frame;
                    ps2_data_d  = frame[0];
                    ps2_clk_d   = 1'b1;
                    bit_cnt_d   = '0;
                    div_cnt_d   = '0;
                    phase_low_d = 1'b0;
                    state_d     = ST_BIT;
                end
            end

            ST_BIT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!phase_low_q) begin
                        phase_low_d = 1'b1;
                        ps2_clk_d   = 1'b0;
                    end else begin
                        // End of a bit period: raise the clock and present
                        // the next bit, or release the lines after stop.
                        phase_low_d = 1'b0;
                        ps2_clk_d   = 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            ps2_data_d = 1'b1;
                            gap_cnt_d  = '0;
                            state_d    = ST_GAP;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + 1'b1;
                            shift_d    = shift_q >> 1;
                            ps2_data_d = shift_q[1];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (seq_q == SEQ_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        seq_d   = seq_q + 2'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_tx
// Bench for ps2_kbd_tx with CLK_DIV=4, GAP=8. A line monitor decodes PS/2
// frames from ps2_clk falling edges and logs accepts, err pulses and line
// activity; a character-level model predicts frames, their timing and the
// activity counts from the accepted characters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_kbd_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;
    localparam int FRAME_CYC = 22 * CLK_DIV;
    localparam int BYTE_CYC  = 1 + FRAME_CYC + GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ascii = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       err;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .ascii    (ascii),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Set-2 make codes from the character table.
    logic [7:0] digit_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] letter_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};

    task automatic ref_map(input logic [7:0] c, output bit hit, output logic [7:0] code);
        hit  = 1'b1;
        code = 8'h00;
        if (c >= "0" && c <= "9")      code = digit_tab[c - 8'h30];
        else if (c >= "A" && c <= "Z") code = letter_tab[c - 8'h41];
        else if (c >= "a" && c <= "z") code = letter_tab[c - 8'h61];
        else                           hit  = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [7:0] acc_c [$];
    int         acc_t [$];
    int         err_t [$];
    logic [7:0] fr_byte [$];
    int         fr_par [$], fr_start [$], fr_stop [$], fr_first [$], fr_space [$];
    int         busy_cnt = 0, clk_low_cnt = 0, data_low_cnt = 0;
    int         mon_nbits = 0;
    logic [10:0] mon_bits;
    int         mon_first = 0, mon_last = 0, mon_sp_ok = 1;
    logic       prev_clk = 1'b1;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_nbits = 0;
            mon_sp_ok = 1;
            prev_clk  = 1'b1;
        end else begin
            if (in_valid && in_ready) begin
                acc_c.push_back(ascii);
                acc_t.push_back(cyc);
            end
            if (err) err_t.push_back(cyc);
            if (busy) busy_cnt++;
            if (!ps2_clk) clk_low_cnt++;
            if (!ps2_data) data_low_cnt++;
            if (prev_clk && !ps2_clk) begin
                if (mon_nbits == 0) mon_first = cyc;
                else if (cyc - mon_last != 2 * CLK_DIV) mon_sp_ok = 0;
                mon_last = cyc;
                mon_bits[mon_nbits] = ps2_data;
                mon_nbits++;
                if (mon_nbits == 11) begin
                    fr_start.push_back(int'(mon_bits[0]));
                    fr_byte.push_back(mon_bits[8:1]);
                    fr_par.push_back(int'(mon_bits[9]));
                    fr_stop.push_back(int'(mon_bits[10]));
                    fr_first.push_back(mon_first);
                    fr_space.push_back(mon_sp_ok);
                    mon_nbits = 0;
                    mon_sp_ok = 1;
                end
            end
            prev_clk = ps2_clk;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic phase_begin();
        acc_c.delete(); acc_t.delete(); err_t.delete();
        fr_byte.delete(); fr_par.delete(); fr_start.delete();
        fr_stop.delete(); fr_first.delete(); fr_space.delete();
        busy_cnt = 0; clk_low_cnt = 0; data_low_cnt = 0;
    endtask

    // Present c until accepted; afterwards either hold in_valid with nxt or
    // drop it and scramble ascii (the DUT must have latched c).
    task automatic drive_char(input logic [7:0] c, input bit hold, input logic [7:0] nxt);
        bit done = 0;
        @(posedge clk); #1;
        ascii    = c;
        in_valid = 1'b1;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                if (hold) ascii = nxt;
                else begin
                    ascii    = 8'($urandom);
                    in_valid = 1'b0;
                end
                done = 1;
            end
        end
        if (!done) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int run = 0;
        for (int i = 0; i < 20000 && run < 3; i++) begin
            @(negedge clk);
            if (!busy && in_ready && !in_valid) run++;
            else run = 0;
        end
        if (run < 3) chk("idle_timeout", 0, 1);
        chk("idle_ready", int'(in_ready), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_clk", int'(ps2_clk), 1);
        chk("idle_data", int'(ps2_data), 1);
    endtask

    // Predict everything from the accepted characters and compare.
    task automatic phase_end(input string name);
        logic [7:0] e_byte [$];
        int         e_first [$];
        int         e_err [$];
        int         e_busy = 0, e_low = 0, e_dlow = 0;
        bit         hit;
        logic [7:0] code;
        logic [7:0] seq [$];
        int         t, n;
        for (int k = 0; k < acc_c.size(); k++) begin
            ref_map(acc_c[k], hit, code);
            if (!hit) begin
                e_err.push_back(acc_t[k] + 1);
                e_busy += 1;
            end else begin
                seq.delete();
                seq.push_back(code);
`ifdef PS2_TX_BREAK_EN
                seq.push_back(8'hF0);
                seq.push_back(code);
`endif
                t = acc_t[k] + CLK_DIV + 2;
                foreach (seq[j]) begin
                    e_byte.push_back(seq[j]);
                    e_first.push_back(t);
                    t += BYTE_CYC;
                    e_low  += 11 * CLK_DIV;
                    // zeros: start, zero data bits, parity when data has odd ones
                    e_dlow += (1 + (8 - $countones(seq[j])) + (($countones(seq[j]) % 2) == 1 ? 1 : 0))
                              * 2 * CLK_DIV;
                end
                e_busy += seq.size() * BYTE_CYC;
            end
        end
        chk({name, "_nframes"}, fr_byte.size(), e_byte.size());
        n = (fr_byte.size() < e_byte.size()) ? fr_byte.size() : e_byte.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_byte"}, int'(fr_byte[i]), int'(e_byte[i]));
            chk({name, "_parity"}, fr_par[i], ($countones(e_byte[i]) % 2 == 0) ? 1 : 0);
            chk({name, "_start"}, fr_start[i], 0);
            chk({name, "_stop"}, fr_stop[i], 1);
            chk({name, "_first_fall"}, fr_first[i], e_first[i]);
            chk({name, "_bit_spacing"}, fr_space[i], 1);
        end
        chk({name, "_nerr"}, err_t.size(), e_err.size());
        n = (err_t.size() < e_err.size()) ? err_t.size() : e_err.size();
        for (int i = 0; i < n; i++) chk({name, "_err_time"}, err_t[i], e_err[i]);
        chk({name, "_busy_cycles"}, busy_cnt, e_busy);
        chk({name, "_clk_low_cycles"}, clk_low_cnt, e_low);
        chk({name, "_data_low_cycles"}, data_low_cnt, e_dlow);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        logic [7:0] c;

        // Reset state, during reset and on the first clocks after release.
        repeat (2) @(negedge clk);
        chk("rst_clk", int'(ps2_clk), 1);
        chk("rst_data", int'(ps2_data), 1);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_ready", int'(in_ready), 1);
            chk("post_rst_clk", int'(ps2_clk), 1);
            chk("post_rst_data", int'(ps2_data), 1);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_err", int'(err), 0);
        end

        phase_begin(); drive_char("A", 0, 8'h00); wait_idle(); phase_end("A");
        phase_begin(); drive_char("0", 0, 8'h00); wait_idle(); phase_end("zero");
        phase_begin(); drive_char("#", 0, 8'h00); wait_idle(); phase_end("hash");

        phase_begin();
        drive_char("z", 1, "B");
        drive_char("B", 0, 8'h00);
        wait_idle();
        phase_end("zB");
        chk("zB_accepts", acc_c.size(), 2);

        // Reset in the middle of the first frame.
        phase_begin();
        drive_char("A", 0, 8'h00);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (mon_nbits >= 6) ok = 1;
        end
        if (!ok) chk("midrst_wait", 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_clk", int'(ps2_clk), 1);
        chk("midrst_data", int'(ps2_data), 1);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_rel_clk", int'(ps2_clk), 1);
        chk("midrst_rel_ready", int'(in_ready), 1);
        phase_begin(); drive_char("A", 0, 8'h00); wait_idle(); phase_end("after_rst");

        // Random characters, some back to back.
        phase_begin();
        for (int k = 0; k < 12; k++) begin
            c = 8'($urandom_range(32, 126));
            drive_char(c, 0, 8'h00);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        phase_end("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 Parameter CLK_DIV, default 50: clk cycles per PS/2 clock half-period; SHALL be at least 2.
REQ-002 Parameter GAP, default 100: idle clk cycles between consecutive bytes.
REQ-003 clk  input  1: system clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 ascii  input  8: character to transmit.
REQ-006 in_valid  input  1: ascii is valid this cycle.
REQ-007 in_ready  output  1: block can accept a character.
REQ-008 ps2_clk  output  1: generated PS/2 clock; idle high.
REQ-009 ps2_data  output  1: PS/2 data line; idle high.
REQ-010 busy  output  1: high from acceptance until the last gap of the sequence ends.
REQ-011 err  output  1: one-cycle pulse when an unsupported character is accepted.

Function
REQ-012 Accept SHALL occur on a cycle with in_valid and in_ready both high; in_ready SHALL be high only in IDLE.
REQ-013 The character-to-scan-code map SHALL be: '0'-'9' map to 45,16,1E,26,25,2E,36,3D,3E,46; 'A'-'Z' and 'a'-'z' both map to set-2 make codes (A=1C, B=32 ... Z=1A), inverse of the receive-side table.
REQ-014 An unmapped character SHALL pulse err the cycle after accept, send no frame, and return to IDLE with in_ready high on the following cycle.
REQ-015 A mapped character SHALL send the byte sequence make code, then F0, then the make code, with each byte followed by GAP idle cycles.
REQ-016 Frame: 11 bits: start 0, data bits 0..7 LSB first, odd parity (data plus parity has an odd count of ones), stop 1.
REQ-017 Each bit period SHALL be 2*CLK_DIV cycles:
- ps2_data is updated at the start of the period while ps2_clk is high.
- ps2_clk stays high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-018 One frame SHALL last exactly 22*CLK_DIV cycles; ps2_clk and ps2_data SHALL be high during gaps and in IDLE.
REQ-019 The FSM states SHALL be IDLE, LOAD (latch the byte and compute parity), BIT (shift out the 11 bits), and GAP. The sequence is IDLE->LOAD->BIT->GAP, then ->LOAD for the next byte or ->IDLE after the last byte.
REQ-020 The first ps2_clk falling edge SHALL occur CLK_DIV+2 cycles after accept: one cycle in LOAD, then the first bit begins.
REQ-021 ascii changes while busy SHALL be ignored, because the character is latched on accept.
REQ-022 The bit counter SHALL count 0..10, and the clock divider 0..CLK_DIV-1, wrapping to 0 at the end of each bit.

Reset
REQ-023 While rst is high, and on the first clock after release:
- state is IDLE, ps2_clk=1, ps2_data=1, in_ready=1, busy=0, err=0.
- counters and shift register are cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously); no partial byte resumes after release.

Configuration
REQ-025 Macro PS2_TX_BREAK_EN defined: the make, F0, make sequence per REQ-015 applies.
REQ-026 Macro PS2_TX_BREAK_EN undefined: only the make code is sent, followed by one GAP, then IDLE; no F0 frame is generated.

Structure
REQ-027 Package ps2_pkg SHALL hold:
- the FSM state enum;
- the BREAK_CODE constant (8'hF0);
- frame-length constants (11 bits);
- the scan-code typedef (8-bit).
REQ-028 Sub-module ascii2scan SHALL be combinational ascii -> {hit, code} and be instanced once; all other logic sits in ps2_kbd_tx.

Verification (CLK_DIV=4, GAP=8)
REQ-029 Send 'A' (41): three frames 1C/p0, F0/p1, 1C/p0; each frame is 88 cycles with 8-cycle gaps; busy falls after the last gap; in_ready returns high.
REQ-030 Send '0' (30): the data bits sampled on ps2_clk falling edges decode to 45 with parity 0; start bit 0, stop bit 1.
REQ-031 Send '#' (23): err pulses for exactly one cycle, ps2_clk/ps2_data stay high, in_ready is high 2 cycles after accept.
REQ-032 Send 'z' (7A) immediately followed by in_valid held with 'B': 'z' emits 1A frames first; 'B' is accepted only after IDLE and emits 32.
REQ-033 Assert rst during bit 5 of the first frame: outputs are high and in_ready=1 within the same cycle; a new 'A' after release transmits a complete correct sequence.
REQ-034 With PS2_TX_BREAK_EN undefined, send 'A': exactly one 1C frame and no F0 observed.
